bip_control: RTL and testbench
==============================

BIP_CONTROL -- requirements
Module: BIP_CONTROL

Interface
REQ-001 SHALL have parameter len_addr, default 11, program-address and operand width.
REQ-002 SHALL have parameter len_data, default 16, instruction width (opcode = bits [len_data-1:len_addr]).
REQ-003 SHALL have parameter len_count, default 16, cycle-counter width.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_start  input  1  start request, sampled only in IDLE.
REQ-007 SHALL have port i_instr  input  len_data  instruction word from program memory Data.
REQ-008 SHALL have port o_addr  output  len_addr  program-memory address (equals PC register).
REQ-009 SHALL have port o_operand  output  len_addr  i_instr[len_addr-1:0], combinational.
REQ-010 SHALL have port o_sel_a  output  2  accumulator source: 0 data RAM, 1 immediate, 2 ALU.
REQ-011 SHALL have port o_sel_b  output  1  ALU operand B: 0 data RAM, 1 immediate.
REQ-012 SHALL have ports o_wr_acc, o_op, o_wr_ram, o_rd_ram  output  1 each  acc write, ALU op (0 add, 1 sub), RAM write, RAM read.
REQ-013 SHALL have port o_halted  output  1  high while in HALT.
REQ-014 SHALL have port o_cycle_count  output  len_count  cycles spent in FETCH/EXEC.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, EXEC, HALT.
REQ-016 IDLE: i_start=1 -> FETCH next cycle; else stay; PC and counter held.
REQ-017 FETCH: o_addr=PC presented for one cycle (memory registers address at this edge); -> EXEC unconditionally.
REQ-018 EXEC: i_instr valid; decode and assert strobes for exactly this cycle; non-HLT -> PC<=PC+1, -> FETCH.
REQ-019 Each instruction SHALL take exactly 2 cycles (FETCH+EXEC).
REQ-020 Decode in EXEC: HLT 00000 none; STO 00001 wr_ram; LD 00010 rd_ram, sel_a=0, wr_acc; LDI 00011 sel_a=1, wr_acc.
REQ-021 Decode in EXEC: ADD 00100 rd_ram, sel_a=2, sel_b=0, op=0, wr_acc; ADDI 00101 sel_a=2, sel_b=1, op=0, wr_acc.
REQ-022 Decode in EXEC: SUB 00110 rd_ram, sel_a=2, sel_b=0, op=1, wr_acc; SUBI 00111 sel_a=2, sel_b=1, op=1, wr_acc.
REQ-023 Opcodes 01000-11111 SHALL act as NOP: no strobes, PC advances.
REQ-024 HLT in EXEC: no strobes, PC unchanged, -> HALT; HALT is absorbing until reset; i_start ignored.
REQ-025 Outside EXEC, o_wr_acc, o_wr_ram, o_rd_ram SHALL be 0 and o_sel_a, o_sel_b, o_op SHALL be 0.
REQ-026 PC SHALL wrap 2^len_addr-1 -> 0 with no flag and no stall.
REQ-027 o_cycle_count SHALL increment by 1 every cycle in FETCH or EXEC, saturate at all-ones, hold in IDLE/HALT.
REQ-028 i_start SHALL be ignored in FETCH, EXEC, HALT.

Reset
REQ-029 reset=1 at posedge SHALL, from any state incl. mid-instruction, force IDLE, PC=0, o_cycle_count=0, o_halted=0, all strobes 0.
REQ-030 reset SHALL take priority over i_start in the same cycle.
REQ-031 After reset deassertion the block SHALL remain in IDLE until i_start=1.

Verification
REQ-032 Program {LDI 5, ADDI 3, STO 0x010, HLT}: start -> EXEC strobes per REQ-020/021 in cycles 2,4,6; o_halted=1 after cycle 8; PC=3; o_cycle_count=8.
REQ-033 Program {LD 0x004, SUB 0x005, SUBI 1, HLT}: rd_ram=1 only in EXEC of LD and SUB; o_op=1 only for SUB/SUBI; o_operand=0x004/0x005/0x001.
REQ-034 Program of 2048 NOPs (opcode 01000): PC wraps 2047 -> 0; o_cycle_count=4096 after one full pass.
REQ-035 reset asserted during EXEC of ADD -> next cycle IDLE, PC=0, strobes 0, count 0; i_start then restarts at address 0.
REQ-036 i_start pulsed during FETCH/EXEC/HALT -> no state change; reset and i_start high together -> IDLE.
REQ-037 len_count=4, 10 NOPs run -> o_cycle_count saturates at 15 and holds.

Source files
------------

// File: rtl/bip_control.sv
// BIP sequencer: two-cycle FETCH/EXEC control FSM with program counter,
// instruction decode strobes and a saturating active-cycle counter.
module bip_control #(
  parameter int len_addr  = 11,
  parameter int len_data  = 16,
  parameter int len_count = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [len_data-1:0]  i_instr,
  output logic [len_addr-1:0]  o_addr,
  output logic [len_addr-1:0]  o_operand,
  output logic [1:0]           o_sel_a,
  output logic                 o_sel_b,
  output logic                 o_wr_acc,
  output logic                 o_op,
  output logic                 o_wr_ram,
  output logic                 o_rd_ram,
  output logic                 o_halted,
  output logic [len_count-1:0] o_cycle_count
);

  localparam int OPW = len_data - len_addr;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t               r_state;
  logic [len_addr-1:0]  r_pc;
  logic [len_count-1:0] r_count;

  logic [OPW-1:0] w_opc;
  logic           w_exec;
  logic           w_run;
  logic           w_hlt;

  assign w_opc     = i_instr[len_data-1:len_addr];
  assign w_exec    = (r_state == S_EXEC);
  assign w_run     = (r_state == S_FETCH) || w_exec;
  assign w_hlt     = (w_opc == OPW'(0));
  assign o_addr    = r_pc;
  assign o_operand = i_instr[len_addr-1:0];
  assign o_halted  = (r_state == S_HALT);
  assign o_cycle_count = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_count <= '0;
    end else begin
      // counter saturates at all-ones rather than wrapping
      if (w_run && !(&r_count))
        r_count <= r_count + len_count'(1);
      unique case (r_state)
        S_IDLE:  if (i_start) r_state <= S_FETCH;
        S_FETCH: r_state <= S_EXEC;
        S_EXEC: begin
          if (w_hlt) begin
            r_state <= S_HALT;
          end else begin
            r_state <= S_FETCH;
            r_pc    <= r_pc + len_addr'(1);
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // strobes are valid only while the fetched word sits on i_instr
  always_comb begin
    o_sel_a  = 2'd0;
    o_sel_b  = 1'b0;
    o_op     = 1'b0;
    o_wr_acc = 1'b0;
    o_wr_ram = 1'b0;
    o_rd_ram = 1'b0;
    if (w_exec) begin
      unique case (1'b1)
        (w_opc == OPW'(1)): begin
          o_wr_ram = 1'b1;
        end
        (w_opc == OPW'(2)): begin
          o_rd_ram = 1'b1;
          o_wr_acc = 1'b1;
        end
        (w_opc == OPW'(3)): begin
          o_sel_a  = 2'd1;
          o_wr_acc = 1'b1;
        end
        (w_opc == OPW'(4)): begin
          o_rd_ram = 1'b1;
          o_sel_a  = 2'd2;
          o_wr_acc = 1'b1;
        end
        (w_opc == OPW'(5)): begin
          o_sel_a  = 2'd2;
          o_sel_b  = 1'b1;
          o_wr_acc = 1'b1;
        end
        (w_opc == OPW'(6)): begin
          o_rd_ram = 1'b1;
          o_sel_a  = 2'd2;
          o_op     = 1'b1;
          o_wr_acc = 1'b1;
        end
        (w_opc == OPW'(7)): begin
          o_sel_a  = 2'd2;
          o_sel_b  = 1'b1;
          o_op     = 1'b1;
          o_wr_acc = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control: programs run from a synchronous ROM model,
// plus a narrow-counter instance for saturation.
module tb_bip_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        start2;
  logic [15:0] instr;
  logic [10:0] addr;
  logic [10:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b, wr_acc, op, wr_ram, rd_ram, halted;
  logic [15:0] count;
  logic [6:0]  strb;

  logic [10:0] s_addr, s_operand;
  logic [1:0]  s_sel_a;
  logic        s_sel_b, s_wr_acc, s_op, s_wr_ram, s_rd_ram, s_halted;
  logic [3:0]  s_count;

  logic [15:0] rom [0:2047];

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] prog [0:3];
  logic [6:0]  exps [0:3];
  logic [10:0] expo [0:3];

  always #5 clk = ~clk;

  always @(posedge clk) instr <= rom[addr];

  assign strb = {sel_a, sel_b, op, wr_acc, wr_ram, rd_ram};

  bip_control u_dut (
    .clk(clk), .reset(reset), .i_start(start), .i_instr(instr),
    .o_addr(addr), .o_operand(operand), .o_sel_a(sel_a),
    .o_sel_b(sel_b), .o_wr_acc(wr_acc), .o_op(op),
    .o_wr_ram(wr_ram), .o_rd_ram(rd_ram), .o_halted(halted),
    .o_cycle_count(count)
  );

  bip_control #(.len_count(4)) u_sat (
    .clk(clk), .reset(reset), .i_start(start2), .i_instr(16'h4000),
    .o_addr(s_addr), .o_operand(s_operand), .o_sel_a(s_sel_a),
    .o_sel_b(s_sel_b), .o_wr_acc(s_wr_acc), .o_op(s_op),
    .o_wr_ram(s_wr_ram), .o_rd_ram(s_rd_ram), .o_halted(s_halted),
    .o_cycle_count(s_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_prog(input string nm);
    for (int i = 0; i < 4; i++) begin
      chk({nm, "_fetch_strb"}, 32'(strb), 32'd0);
      chk({nm, "_fetch_addr"}, 32'(addr), 32'(i));
      @(negedge clk);
      chk({nm, "_exec_strb"}, 32'(strb), 32'(exps[i]));
      chk({nm, "_exec_opnd"}, 32'(operand), 32'(expo[i]));
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 16'h4000;
    reset  = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_strb", 32'(strb), 32'd0);
    repeat (3) @(negedge clk);
    chk("idle_hold", 32'(count), 32'd0);

    // LDI 5, ADDI 3, STO 0x010, HLT
    prog = '{16'h1805, 16'h2803, 16'h0810, 16'h0000};
    exps = '{7'b0100100, 7'b1010100, 7'b0000010, 7'b0000000};
    expo = '{11'h005, 11'h003, 11'h010, 11'h000};
    for (int i = 0; i < 4; i++) rom[i] = prog[i];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_prog("p1");
    chk("p1_halted", 32'(halted), 32'd1);
    chk("p1_pc", 32'(addr), 32'd3);
    chk("p1_count", 32'(count), 32'd8);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    chk("halt_start_h", 32'(halted), 32'd1);
    chk("halt_start_c", 32'(count), 32'd8);
    chk("halt_start_pc", 32'(addr), 32'd3);

    // reset out of HALT, then LD/SUB/SUBI with start held high throughout
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2_halted", 32'(halted), 32'd0);
    chk("rst2_count", 32'(count), 32'd0);
    prog = '{16'h1004, 16'h3005, 16'h3801, 16'h0000};
    exps = '{7'b0000101, 7'b1001101, 7'b1011100, 7'b0000000};
    expo = '{11'h004, 11'h005, 11'h001, 11'h000};
    for (int i = 0; i < 4; i++) rom[i] = prog[i];
    start = 1'b1;
    @(negedge clk);
    run_prog("p2");
    start = 1'b0;
    chk("p2_halted", 32'(halted), 32'd1);
    chk("p2_count", 32'(count), 32'd8);

    // reset (with start also high) during EXEC of ADD
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rom[0] = 16'h2007;
    rom[1] = 16'h0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("add_strb", 32'(strb), 32'b1000101);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("midrst_addr", 32'(addr), 32'd0);
    chk("midrst_strb", 32'(strb), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_halted", 32'(halted), 32'd0);
    repeat (2) @(negedge clk);
    chk("midrst_idle", 32'(count), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_addr", 32'(addr), 32'd0);
    @(negedge clk);
    chk("restart_strb", 32'(strb), 32'b1000101);
    repeat (3) @(negedge clk);
    chk("restart_halt", 32'(halted), 32'd1);
    chk("restart_pc", 32'(addr), 32'd1);

    // 2048 NOPs: PC wraps, opcode 11111 also behaves as NOP
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2048; i++) rom[i] = 16'h4000;
    rom[5] = 16'hF800;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 4096; c++) begin
      @(negedge clk);
      if (c == 11) chk("nop_11111", 32'(strb), 32'd0);
      if (c == 4094) chk("nop_pc_max", 32'(addr), 32'd2047);
    end
    chk("nop_wrap_pc", 32'(addr), 32'd0);
    chk("nop_count", 32'(count), 32'd4096);
    chk("nop_running", 32'(halted), 32'd0);

    // 4-bit counter saturation on the second instance
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("sat_rst", 32'(s_count), 32'd0);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (14) @(negedge clk);
    chk("sat_14", 32'(s_count), 32'd14);
    repeat (6) @(negedge clk);
    chk("sat_20", 32'(s_count), 32'd15);
    repeat (10) @(negedge clk);
    chk("sat_hold", 32'(s_count), 32'd15);
    chk("sat_pc", 32'(s_addr), 32'd15);
    chk("sat_main_idle", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
